// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the sync_ram_2p storage primitive.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clear_state_t;

  // Widest word the parity helper covers; narrower words are zero-extended.
  localparam int PAR_MAX_WIDTH = 64;

  function automatic logic even_parity(input logic [PAR_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every RAM word once after reset or on a start request.
module ram_clear_seq
  import sync_ram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  clear_state_t          state;
  logic [ADDR_WIDTH-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr;

endmodule

// File: rtl/sync_ram_2p.sv
// Synchronous 1W/1R RAM with write-first bypass, zero-fill sequencer and range checks.
// Optional per-word even parity with injection when RAM_PARITY_EN is defined.
module sync_ram_2p
  import sync_ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  rd_en_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                  clr_in,
`ifdef RAM_PARITY_EN
  input  logic                  par_inj_in,
  output logic                  par_err_out,
`endif
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  output logic                  addr_err_out,
  output logic                  busy_out
);

`ifdef RAM_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [MEM_WIDTH-1:0]  mem [DEPTH];
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  accept;
  logic                  wr_do;
  logic                  rd_do;
  logic                  bypass;
  logic                  err_next;
  logic [MEM_WIDTH-1:0]  wr_word;
  logic [MEM_WIDTH-1:0]  rd_word;

  ram_clear_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk      (clk_in),
    .rst      (rst_in),
    .start    (clr_in),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign busy_out    = busy;
  assign wr_in_range = ({1'b0, wr_addr_in} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr_in} < DEPTH_LIM);
  // A clear request wins over any read or write presented alongside it.
  assign accept      = !busy && !clr_in;
  assign wr_do       = accept && wr_en_in && wr_in_range;
  assign rd_do       = accept && rd_en_in;
  assign bypass      = wr_do && rd_in_range && (wr_addr_in == rd_addr_in);
  assign err_next    = accept && ((wr_en_in && !wr_in_range) || (rd_en_in && !rd_in_range));
  assign rd_word     = mem[rd_addr_in];

`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(PAR_MAX_WIDTH'(wr_data_in)) ^ par_inj_in, wr_data_in};
`else
  assign wr_word = wr_data_in;
`endif

  // All-zero words carry even parity 0, so the clear value is simply zero.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (wr_do) begin
        mem[wr_addr_in] <= wr_word;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_data_out  <= '0;
      rd_valid_out <= 1'b0;
      addr_err_out <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err_out  <= 1'b0;
`endif
    end else begin
      rd_valid_out <= rd_do;
      addr_err_out <= err_next;
`ifdef RAM_PARITY_EN
      par_err_out  <= 1'b0;
`endif
      if (rd_do) begin
        if (!rd_in_range) begin
          rd_data_out <= '0;
        end else if (bypass) begin
          rd_data_out <= wr_data_in;
        end else begin
          rd_data_out <= rd_word[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
          par_err_out <= rd_word[DATA_WIDTH] ^
                         even_parity(PAR_MAX_WIDTH'(rd_word[DATA_WIDTH-1:0]));
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_2p.sv
// Randomised checking of sync_ram_2p: DEPTH=16 and DEPTH=10 instances share stimulus.
// Parity checks are included when RAM_PARITY_EN is defined.
module tb_sync_ram_2p;

  logic       clk;
  logic       rst;
  logic       wrEn;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic       rdEn;
  logic [3:0] rdAddr;
  logic       clr;
  logic       parInj;

  logic [7:0] rdDataA, rdDataB;
  logic       rdValidA, rdValidB;
  logic       addrErrA, addrErrB;
  logic       busyA, busyB;
  logic       parErrA, parErrB;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural reference state, one slot per instance (0: DEPTH 16, 1: DEPTH 10).
  int         depthOf [2] = '{16, 10};
  logic [7:0] modelMem [2][16];
  logic       modelInj [2][16];
  int         busyLeft [2];
  logic [7:0] expData  [2];
  logic       expValid [2];
  logic       expErr   [2];
  logic       expPar   [2];

  sync_ram_2p #(.DATA_WIDTH(8), .DEPTH(16)) dutA (
    .clk_in       (clk),
    .rst_in       (rst),
    .wr_en_in     (wrEn),
    .wr_addr_in   (wrAddr),
    .wr_data_in   (wrData),
    .rd_en_in     (rdEn),
    .rd_addr_in   (rdAddr),
    .clr_in       (clr),
`ifdef RAM_PARITY_EN
    .par_inj_in   (parInj),
    .par_err_out  (parErrA),
`endif
    .rd_data_out  (rdDataA),
    .rd_valid_out (rdValidA),
    .addr_err_out (addrErrA),
    .busy_out     (busyA)
  );

  sync_ram_2p #(.DATA_WIDTH(8), .DEPTH(10)) dutB (
    .clk_in       (clk),
    .rst_in       (rst),
    .wr_en_in     (wrEn),
    .wr_addr_in   (wrAddr),
    .wr_data_in   (wrData),
    .rd_en_in     (rdEn),
    .rd_addr_in   (rdAddr),
    .clr_in       (clr),
`ifdef RAM_PARITY_EN
    .par_inj_in   (parInj),
    .par_err_out  (parErrB),
`endif
    .rd_data_out  (rdDataB),
    .rd_valid_out (rdValidB),
    .addr_err_out (addrErrB),
    .busy_out     (busyB)
  );

`ifndef RAM_PARITY_EN
  assign parErrA = 1'b0;
  assign parErrB = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic wipeModel(input int d);
    for (int a = 0; a < 16; a++) begin
      modelMem[d][a] = 8'h00;
      modelInj[d][a] = 1'b0;
    end
  endtask

  // One clock edge of the reference: clear lasts depth cycles, reads see write-first data.
  task automatic modelStep(input int d);
    logic wrOk, rdOk;
    if (rst) begin
      busyLeft[d] = depthOf[d];
      wipeModel(d);
      expData[d] = 8'h00; expValid[d] = 1'b0; expErr[d] = 1'b0; expPar[d] = 1'b0;
    end else if (busyLeft[d] > 0) begin
      busyLeft[d]--;
      expValid[d] = 1'b0; expErr[d] = 1'b0; expPar[d] = 1'b0;
    end else if (clr) begin
      busyLeft[d] = depthOf[d];
      wipeModel(d);
      expValid[d] = 1'b0; expErr[d] = 1'b0; expPar[d] = 1'b0;
    end else begin
      wrOk = wrEn && (int'(wrAddr) < depthOf[d]);
      rdOk = int'(rdAddr) < depthOf[d];
      expValid[d] = rdEn;
      expErr[d]   = (wrEn && !wrOk) || (rdEn && !rdOk);
      expPar[d]   = 1'b0;
      if (rdEn) begin
        if (!rdOk) expData[d] = 8'h00;
        else if (wrOk && wrAddr == rdAddr) expData[d] = wrData;
        else begin
          expData[d] = modelMem[d][rdAddr];
          expPar[d]  = modelInj[d][rdAddr];
        end
      end
      if (wrOk) begin
        modelMem[d][wrAddr] = wrData;
        modelInj[d][wrAddr] = parInj;
      end
    end
  endtask

  task automatic checkDuts();
    checkOutput("busyA",    32'(busyA),    32'(busyLeft[0] > 0));
    checkOutput("validA",   32'(rdValidA), 32'(expValid[0]));
    checkOutput("addrErrA", 32'(addrErrA), 32'(expErr[0]));
    checkOutput("dataA",    32'(rdDataA),  32'(expData[0]));
    checkOutput("busyB",    32'(busyB),    32'(busyLeft[1] > 0));
    checkOutput("validB",   32'(rdValidB), 32'(expValid[1]));
    checkOutput("addrErrB", 32'(addrErrB), 32'(expErr[1]));
    checkOutput("dataB",    32'(rdDataB),  32'(expData[1]));
`ifdef RAM_PARITY_EN
    checkOutput("parErrA",  32'(parErrA),  32'(expPar[0]));
    checkOutput("parErrB",  32'(parErrB),  32'(expPar[1]));
`endif
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [3:0] wa,
                               input logic [7:0] wd, input logic re, input logic [3:0] ra,
                               input logic cl, input logic inj);
    rst = r; wrEn = we; wrAddr = wa; wrData = wd;
    rdEn = re; rdAddr = ra; clr = cl; parInj = inj;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkDuts();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readAll();
    for (int a = 0; a < 16; a++) applyStimulus(0, 0, 0, 0, 1, 4'(a), 0, 0);
    idleCycles(1);
  endtask

  task automatic randomCycle(input bit allowCtrl);
    logic r, cl;
    r  = allowCtrl && ($urandom_range(0, 199) == 0);
    cl = allowCtrl && ($urandom_range(0, 39) == 0);
    applyStimulus(r, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom),
                  4'($urandom), cl, 1'($urandom_range(0, 7) == 0));
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    rdEn = 1'b0; rdAddr = '0; clr = 1'b0; parInj = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busyLeft[d] = depthOf[d];
      wipeModel(d);
      expData[d] = 8'h00; expValid[d] = 1'b0; expErr[d] = 1'b0; expPar[d] = 1'b0;
    end

    $display("[TB] reset and power-up clear");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(16);
    readAll();

    $display("[TB] directed writes, bypass and range errors");
    applyStimulus(0, 1, 4'd3, 8'hA5, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd3, 0, 0);
    applyStimulus(0, 1, 4'd7, 8'h3C, 1, 4'd7, 0, 0);
    applyStimulus(0, 1, 4'd12, 8'h55, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd12, 0, 0);
    applyStimulus(0, 1, 4'd13, 8'h66, 1, 4'd14, 0, 0);
    idleCycles(1);

    $display("[TB] fill, clear with colliding write, requests while busy");
    for (int a = 0; a < 16; a++) applyStimulus(0, 1, 4'(a), 8'(a * 17 + 1), 0, 0, 0, 0);
    applyStimulus(0, 1, 4'd5, 8'hEE, 1, 4'd5, 1, 0);
    for (int i = 0; i < 16; i++) randomCycle(0);
    readAll();

    $display("[TB] reset in the middle of a clear");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idleCycles(8);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(16);
    readAll();

`ifdef RAM_PARITY_EN
    $display("[TB] parity injection");
    applyStimulus(0, 1, 4'd2, 8'hFF, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd2, 0, 0);
    applyStimulus(0, 1, 4'd2, 8'hFF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'd2, 0, 0);
    applyStimulus(0, 1, 4'd4, 8'h81, 1, 4'd4, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 0, 0);
    idleCycles(1);
`endif

    $display("[TB] randomised traffic");
    for (int i = 0; i < 600; i++) randomCycle(1);
    idleCycles(17);
    readAll();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sync_ram_2p.md
# sync_ram_2p

Parametrised synchronous two-port RAM (one write port, one read port) succeeding the team's 16x8 asynchronous RAM. Adds a clock, configurable width and depth, a one-cycle registered read with write-first bypass, a hardware clear sequencer that zero-fills the array after reset or on request, and out-of-range address detection. It serves as the general storage primitive for buffers and lookup tables in the design.

## Interface
- DATA_WIDTH, 8, bits per word (>=1)
- DEPTH, 16, number of words (>=2, need not be a power of 2)
- ADDR_WIDTH, $clog2(DEPTH), derived localparam; not overridable
- clk_in  input  1  single clock; all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- wr_en_in  input  1  write request this cycle
- wr_addr_in  input  ADDR_WIDTH  write address
- wr_data_in  input  DATA_WIDTH  write data
- rd_en_in  input  1  read request this cycle
- rd_addr_in  input  ADDR_WIDTH  read address
- clr_in  input  1  start a full-array clear (single-cycle pulse sufficient)
- rd_data_out  output  DATA_WIDTH  registered read data
- rd_valid_out  output  1  one-cycle pulse: rd_data_out valid
- addr_err_out  output  1  one-cycle pulse: an accepted request used an address >= DEPTH
- busy_out  output  1  clear sequencer active; requests dropped

## Operation
- FSM states: CLEAR, IDLE. Reset state CLEAR, clear pointer 0.
- CLEAR: each cycle write all-zeros to mem[ptr], ptr++; on the cycle ptr==DEPTH-1 write and go to IDLE. Duration exactly DEPTH cycles. busy_out = (state==CLEAR).
- In CLEAR: wr_en_in, rd_en_in, clr_in ignored; no rd_valid_out, no addr_err_out.
- IDLE + clr_in: enter CLEAR next cycle, ptr=0. Any wr/rd in that same cycle is dropped (clear has priority).
- IDLE write: wr_en_in and wr_addr_in<DEPTH -> mem[wr_addr_in]=wr_data_in at the edge. Address >=DEPTH: no write, addr_err_out pulses.
- IDLE read: rd_en_in -> next cycle rd_valid_out=1, rd_data_out=mem[rd_addr_in]. Address >=DEPTH: rd_valid_out=1, rd_data_out=0, addr_err_out=1.
- Read and write to the same valid address in the same cycle: write-first; rd_data_out returns wr_data_in.
- Simultaneous write error and read error: single addr_err_out pulse.
- rd_data_out holds its last value when no read; it is not cleared by the clear sequencer.
- Reset mid-clear or mid-operation: restart CLEAR from ptr 0; in-flight read discarded.

## Timing
- Reset values: rd_data_out=0, rd_valid_out=0, addr_err_out=0, busy_out=1 (CLEAR).
- After rst_in deasserts: busy_out stays high DEPTH cycles, then 0; first request accepted on the first cycle busy_out=0.
- Read latency 1 cycle; throughput 1 read + 1 write per cycle.
- Write visible to a read issued the following cycle (and the same cycle via bypass).
- clr_in accepted -> busy_out high from next cycle for DEPTH cycles.

## Configuration
- RAM_PARITY_EN defined: each word stores an extra even-parity bit; adds input par_inj_in (1 bit) that inverts the stored parity bit when written with wr_en_in; adds output par_err_out (1 bit, reset 0), pulsed with rd_valid_out when stored parity mismatches data. Clear writes zero data with correct parity. Bypassed reads never flag. Out-of-range reads do not flag.
- Undefined: no parity storage, no par_inj_in/par_err_out ports; memory is exactly DATA_WIDTH x DEPTH.

## Structure
- Package sync_ram_pkg: state enum (CLEAR, IDLE), even-parity function.
- One sub-module: ram_clear_seq (FSM + pointer; outputs busy, clear write enable, clear address). Array, bypass, and error logic stay in the top.

## Test plan
- Reset, DEPTH=16: busy_out=1 for 16 cycles after release; then read addresses 0..15 -> all 8'h00, rd_valid_out one cycle after each rd_en_in.
- Write 8'hA5 to 3, next cycle read 3 -> rd_data_out=8'hA5 one cycle later; same-cycle write 8'h3C/read of 7 -> 8'h3C.
- DEPTH=10: write to 12 -> addr_err_out pulse, no write; read 12 -> rd_data_out=0, rd_valid_out=1, addr_err_out=1.
- Fill memory, pulse clr_in with wr_en_in to 5 -> write dropped, busy_out 16 cycles, all reads return 0; requests during busy produce no rd_valid_out.
- Assert rst_in at clear pointer 8 -> clear restarts, busy_out stays high 16 cycles after release.
- RAM_PARITY_EN: write 8'hFF with par_inj_in=1 to 2, read 2 -> par_err_out=1; rewrite without injection -> par_err_out=0.
